// File: rtl/ram_port2_arbiter.sv
// ram_port2_arbiter: shares the RAM data port (port2) between the CPU (req0) and the debug/loader (req1).
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; the default build gives req0 fixed priority.
`timescale 1ns/1ps
module ram_port2_arbiter #(
  parameter int WR_LATENCY = 2,
  parameter int MODE_W     = 3  // width of the mem_mode access width/sign encoding
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [31:0]       req0_adr,
  input  logic [31:0]       req0_wdata,
  input  logic [MODE_W-1:0] req0_mode,
  output logic              req0_ack,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [31:0]       req1_adr,
  input  logic [31:0]       req1_wdata,
  input  logic [MODE_W-1:0] req1_mode,
  output logic              req1_ack,
  output logic [31:0]       rdata,
  output logic              busy,
  input  logic              ram_iregavail,
  input  logic              ram_port2avail,
  input  logic [31:0]       ram_port2o,
  output logic              ram_port2en,
  output logic              ram_port2wen,
  output logic [31:0]       ram_port2adr,
  output logic [31:0]       ram_port2i,
  output logic [MODE_W-1:0] ram_memmode
);
  localparam int CNT_W = $clog2(WR_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, DONE} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              we_q, we_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              winner;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == DONE) last_grant_d = grant_q;
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end

  assign winner = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;
`else
  assign winner = ~req0_valid;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d = winner;
          we_d    = winner ? req1_we    : req0_we;
          adr_d   = winner ? req1_adr   : req0_adr;
          wdata_d = winner ? req1_wdata : req0_wdata;
          mode_d  = winner ? req1_mode  : req0_mode;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // The RAM only takes port2 while it sits in its fetch/idle state.
        if (ram_iregavail) begin
          if (we_q) begin
            state_d = WAIT_WR;
            cnt_d   = CNT_W'(WR_LATENCY);
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (ram_port2avail) begin
          rdata_d = ram_port2o;
          state_d = DONE;
        end
      end
      WAIT_WR: begin
        if (cnt_q == CNT_W'(1)) state_d = DONE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      mode_q  <= mode_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign req0_ack     = (state_q == DONE) && !grant_q;
  assign req1_ack     = (state_q == DONE) &&  grant_q;
  assign rdata        = rdata_q;
  assign ram_port2en  = (state_q == ISSUE);
  assign ram_port2wen = we_q;
  assign ram_port2adr = adr_q;
  assign ram_port2i   = wdata_q;
  assign ram_memmode  = mode_q;

  // The granted requester must keep valid up while its transaction is in flight.
  a_hold_valid: assert property (@(posedge clk) disable iff (reset)
    (state_q inside {ISSUE, WAIT_RD, WAIT_WR}) |-> (grant_q ? req1_valid : req0_valid));

endmodule
